sum_accumulator: RTL and testbench

Downstream consumer of the carry-select adder's `sum_out` (N+1 bits). It accepts a stream of sums over a valid/ready handshake and adds each one into a widened accumulator. A group closes on `in_last`, or automatically when the term count saturates, and the group total is then presented on an output valid/ready handshake. It sits between the adder and the reduction/writeback logic.

---
 rtl/sum_accumulator_if.sv | 28 ++
 rtl/sum_accumulator.sv | 86 ++++++++
 tb/tb_sum_accumulator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Stream interface for sum_accumulator: input term channel and output result
// channel. Both use valid/ready handshakes.
interface sum_accumulator_if #(
  parameter int N     = 64,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_sum;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N+CNT_W:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_auto;

  // Producer of terms and consumer of results
  modport master (
    output in_valid, in_sum, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_auto
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_sum, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_auto
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a stream of unsigned adder sums into a widened total. A group
// closes on in_last or when the term count reaches 2^CNT_W-1; the total is
// then held on the output handshake until consumed.
module sum_accumulator #(
  parameter int N     = 64,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  sum_accumulator_if.slave   bus
);
  localparam int ACC_W = N + CNT_W + 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] res_acc;
  logic [CNT_W-1:0] res_count;
  logic             res_auto;

  logic             accept;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             sat;

  // Handshake flags come from the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_acc   = res_acc;
  assign bus.out_count = res_count;
  assign bus.out_auto  = res_auto;

  // Width of acc covers (2^CNT_W-1) maximal terms, so the add cannot wrap.
  assign accept   = bus.in_valid & bus.in_ready;
  assign acc_next = acc + {{(ACC_W-N-1){1'b0}}, bus.in_sum};
  assign cnt_next = cnt + 1'b1;
  assign sat      = (cnt_next == {CNT_W{1'b1}});

  // Group FSM: accumulate terms, close on last/saturation, hold for handshake.
  // clr outranks everything, including a term accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      res_acc   <= '0;
      res_count <= '0;
      res_auto  <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      res_acc   <= '0;
      res_count <= '0;
      res_auto  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last || sat) begin
              res_acc   <= acc_next;
              res_count <= cnt_next;
              // An explicit last wins over saturation for the auto flag.
              res_auto  <= ~bus.in_last & sat;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator (N=64, CNT_W=4): reset, normal groups,
// saturation, backpressure and clr behaviour.
module tb_sum_accumulator;
  localparam int N     = 64;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic clr;
  int   errors;
  int   checks;

  sum_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  sum_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and wait (bounded) until it is accepted.
  task automatic send(input logic [N:0] sum, input logic last);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = sum;
    bus.in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    logic [N:0]         big;
    logic [N:0]         sat_term;
    logic [N+CNT_W:0]   sat_total;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_acc",   bus.out_acc,   0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_auto",  bus.out_auto,  0);
    #10 rst_n = 1'b1;
    tick();

    // Reset mid-group
    send(65'd5, 1'b0);
    send(65'd5, 1'b0);
    send(65'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready",  bus.in_ready,  1);
    #2 rst_n = 1'b1;
    tick();
    chk("postrst_in_ready", bus.in_ready, 1);
    send(65'd7, 1'b1);
    chk("postrst_valid", bus.out_valid, 1);
    chk("postrst_acc",   bus.out_acc,   7);
    chk("postrst_count", bus.out_count, 1);
    chk("postrst_auto",  bus.out_auto,  0);
    tick();
    chk("postrst_valid_low", bus.out_valid, 0);

    // Normal group: 2^64 + 2^64 + 3
    big = 65'd1 << 64;
    send(big, 1'b0);
    send(big, 1'b0);
    send(65'd3, 1'b1);
    chk("norm_valid", bus.out_valid, 1);
    chk("norm_ready", bus.in_ready,  0);
    chk("norm_acc",   bus.out_acc,   (128'd1 << 65) + 128'd3);
    chk("norm_count", bus.out_count, 3);
    chk("norm_auto",  bus.out_auto,  0);
    tick();
    chk("norm_valid_low", bus.out_valid, 0);
    chk("norm_ready_hi",  bus.in_ready,  1);

    // Saturation: 15 terms of 2^65-2 without last
    sat_term  = (65'd1 << 65) - 65'd2;
    sat_total = 69'd15 * ((69'd1 << 65) - 69'd2);
    for (int i = 0; i < 15; i++) send(sat_term, 1'b0);
    chk("sat_valid", bus.out_valid, 1);
    chk("sat_acc",   bus.out_acc,   sat_total);
    chk("sat_count", bus.out_count, 15);
    chk("sat_auto",  bus.out_auto,  1);
    send(65'd1, 1'b1);
    chk("sat_next_acc",   bus.out_acc,   1);
    chk("sat_next_count", bus.out_count, 1);
    chk("sat_next_auto",  bus.out_auto,  0);
    // Saturation coinciding with last
    for (int i = 0; i < 14; i++) send(sat_term, 1'b0);
    send(sat_term, 1'b1);
    chk("satlast_acc",   bus.out_acc,   sat_total);
    chk("satlast_count", bus.out_count, 15);
    chk("satlast_auto",  bus.out_auto,  0);
    tick();

    // Backpressure
    bus.out_ready = 1'b0;
    send(65'd10, 1'b0);
    send(65'd20, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready",  bus.in_ready,  0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_acc",       bus.out_acc,   30);
      chk("bp_count",     bus.out_count, 2);
      chk("bp_auto",      bus.out_auto,  0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", bus.out_valid, 0);
    chk("bp_rel_ready", bus.in_ready,  1);

    // clr together with an accepted term
    send(65'd9, 1'b0);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sum   = 65'd4;
    bus.in_last  = 1'b1;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("clr_acc_valid", bus.out_valid, 0);
    chk("clr_acc_ready", bus.in_ready,  1);
    send(65'd1, 1'b1);
    chk("clr_acc_total", bus.out_acc,   1);
    chk("clr_acc_count", bus.out_count, 1);
    tick();

    // clr while holding a result
    bus.out_ready = 1'b0;
    send(65'd6, 1'b1);
    chk("clrh_pre_valid", bus.out_valid, 1);
    chk("clrh_pre_acc",   bus.out_acc,   6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrh_valid", bus.out_valid, 0);
    chk("clrh_acc",   bus.out_acc,   0);
    chk("clrh_count", bus.out_count, 0);
    chk("clrh_auto",  bus.out_auto,  0);
    chk("clrh_ready", bus.in_ready,  1);
    bus.out_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
